constant_splitter: RTL and testbench

//  Inverse of the immediate extender: takes a full 16-bit constant and emits the minimal

---
 rtl/constant_splitter_pkg.sv | 24 ++
 rtl/constant_splitter_if.sv | 32 +++
 rtl/constant_plan.sv | 49 ++++
 rtl/constant_splitter.sv | 112 +++++++++++
 tb/tb_constant_splitter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/constant_splitter_pkg.sv
// Shared definitions for the constant splitter and the fetch-side immediate
// extender it feeds.
//   DATA_W   : width of a full constant (fixed by the ISA at 16)
//   CONST_W  : width of the constante field carried by one beat
//   mode_t   : extender mode carried on controle
//   state_t  : splitter sequencing state
package constant_splitter_pkg;

  localparam int DATA_W  = 16;
  localparam int CONST_W = 11;

  typedef enum logic [1:0] {
    MODE_SEXT = 2'b00,  // sign-extend constante[10:0]
    MODE_ZEXT = 2'b01,  // zero-extend constante[10:0]
    MODE_HI   = 2'b10   // constante[7:0] lands in [15:8], low byte zero
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT1 = 2'b01,
    BEAT2 = 2'b10
  } state_t;

endpackage

// File: rtl/constant_splitter_if.sv
// Stream bundle around the constant splitter.
//   valor / valor_valid / valor_ready           : constants coming in
//   controle / constante / merge / last /
//   beat_valid / beat_ready                     : extender beats going out
// master : the side that supplies constants and consumes beats
// slave  : the splitter itself
interface constant_splitter_if #(
  parameter int DATA_W  = constant_splitter_pkg::DATA_W,
  parameter int CONST_W = constant_splitter_pkg::CONST_W
);

  logic [DATA_W-1:0]  valor;
  logic               valor_valid;
  logic               valor_ready;
  logic [1:0]         controle;
  logic [CONST_W-1:0] constante;
  logic               merge;
  logic               last;
  logic               beat_valid;
  logic               beat_ready;

  modport master (
    output valor, valor_valid, beat_ready,
    input  valor_ready, controle, constante, merge, last, beat_valid
  );

  modport slave (
    input  valor, valor_valid, beat_ready,
    output valor_ready, controle, constante, merge, last, beat_valid
  );

endinterface

// File: rtl/constant_plan.sv
// Combinational classifier: decides how a 16-bit constant is rebuilt by the
// extender, trying the cheapest single-beat form first.
//   valor        in  : constant to encode
//   two_beats    out : constant needs a high beat plus a merged low beat
//   first_mode   out : extender mode of the first (or only) beat
//   first_const  out : constante field of the first (or only) beat
//   second_const out : constante field of the merged low beat
module constant_plan
  import constant_splitter_pkg::*;
#(
  parameter int ALLOW_ZEXT = 1
) (
  input  logic [DATA_W-1:0]  valor,
  output logic               two_beats,
  output mode_t              first_mode,
  output logic [CONST_W-1:0] first_const,
  output logic [CONST_W-1:0] second_const
);

  logic sext_ok;
  logic zext_ok;
  logic low_zero;

  // Bits 15..10 identical means the value is reachable by sign-extending 11 bits.
  assign sext_ok  = (valor[15:10] == {6{valor[15]}});
  assign zext_ok  = (ALLOW_ZEXT != 0) && (valor[15:11] == 5'd0);
  assign low_zero = (valor[7:0] == 8'd0);

  // The low beat is only used in the two-beat form, always zero-extended and
  // ORed over the high beat, so its field never depends on the classification.
  assign second_const = {3'b000, valor[7:0]};

  always_comb begin
    two_beats   = 1'b0;
    first_mode  = MODE_SEXT;
    first_const = valor[10:0];
    if (sext_ok) begin
      first_mode = MODE_SEXT;
    end else if (zext_ok) begin
      first_mode = MODE_ZEXT;
    end else begin
      // Either the high byte alone suffices, or it is followed by a merged low beat.
      first_mode  = MODE_HI;
      first_const = {3'b000, valor[15:8]};
      two_beats   = !low_zero;
    end
  end

endmodule

// File: rtl/constant_splitter.sv
// Splits a full 16-bit constant into the minimal sequence of extender beats
// that rebuilds it (OR-ing merged beats into the previous one).
//   clock    in  : single clock, rising edge
//   reset_n  in  : asynchronous active-low reset
//   bus      slave modport of constant_splitter_if
//              valor/valor_valid/valor_ready : incoming constants
//              controle/constante/merge/last/beat_valid/beat_ready : beats out
//   n_pares  out : saturating count of constants that needed two beats
module constant_splitter #(
  parameter int DATA_W     = constant_splitter_pkg::DATA_W,
  parameter int CONST_W    = constant_splitter_pkg::CONST_W,
  parameter int ALLOW_ZEXT = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  constant_splitter_if.slave bus,
  output logic [15:0]        n_pares
);

  import constant_splitter_pkg::*;

  state_t             state_reg;
  mode_t              controle_reg;
  logic [CONST_W-1:0] constante_reg;
  logic [CONST_W-1:0] second_reg;
  logic               merge_reg;
  logic               last_reg;
  logic               beat_valid_reg;
  logic [15:0]        n_pares_reg;

  logic [DATA_W-1:0]  valor_in;
  logic               two_beats;
  mode_t              first_mode;
  logic [CONST_W-1:0] first_const;
  logic [CONST_W-1:0] second_const;

  logic               final_taken;
  logic               accept;
  logic               advance;
  logic               pair_done;

  assign valor_in = bus.valor;

  constant_plan #(
    .ALLOW_ZEXT (ALLOW_ZEXT)
  ) u_plan (
    .valor        (valor_in),
    .two_beats    (two_beats),
    .first_mode   (first_mode),
    .first_const  (first_const),
    .second_const (second_const)
  );

  // A new constant may only enter when nothing is pending or the final beat
  // leaves this very cycle; this gives one constant per cycle for single-beat
  // encodings and blocks acceptance while a non-final beat is outstanding.
  assign final_taken     = beat_valid_reg && last_reg && bus.beat_ready;
  assign bus.valor_ready = (state_reg == IDLE) || final_taken;
  assign accept          = bus.valor_valid && bus.valor_ready;
  assign advance         = (state_reg == BEAT1) && !last_reg && bus.beat_ready;
  assign pair_done       = (state_reg == BEAT2) && bus.beat_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      controle_reg   <= MODE_SEXT;
      constante_reg  <= '0;
      second_reg     <= '0;
      merge_reg      <= 1'b0;
      last_reg       <= 1'b0;
      beat_valid_reg <= 1'b0;
      n_pares_reg    <= 16'd0;
    end else begin
      // accept and advance are exclusive: accept needs IDLE or a final beat.
      if (accept) begin
        state_reg      <= BEAT1;
        controle_reg   <= first_mode;
        constante_reg  <= first_const;
        second_reg     <= second_const;
        merge_reg      <= 1'b0;
        last_reg       <= !two_beats;
        beat_valid_reg <= 1'b1;
      end else if (advance) begin
        state_reg      <= BEAT2;
        controle_reg   <= MODE_ZEXT;
        constante_reg  <= second_reg;
        merge_reg      <= 1'b1;
        last_reg       <= 1'b1;
        beat_valid_reg <= 1'b1;
      end else if (final_taken) begin
        state_reg      <= IDLE;
        controle_reg   <= MODE_SEXT;
        constante_reg  <= '0;
        merge_reg      <= 1'b0;
        last_reg       <= 1'b0;
        beat_valid_reg <= 1'b0;
      end

      if (pair_done && (n_pares_reg != 16'hFFFF)) begin
        n_pares_reg <= n_pares_reg + 16'd1;
      end
    end
  end

  assign bus.controle   = controle_reg;
  assign bus.constante  = constante_reg;
  assign bus.merge      = merge_reg;
  assign bus.last       = last_reg;
  assign bus.beat_valid = beat_valid_reg;
  assign n_pares        = n_pares_reg;

endmodule

// File: tb/tb_constant_splitter.sv
// Bench for constant_splitter: table of known encodings, back-to-back and
// stall sequences, randomized traffic against a scoreboard, a ZEXT-disabled
// instance, and a reset in the middle of a two-beat constant.
module tb_constant_splitter;

  typedef struct packed {
    logic [1:0]  c;
    logic [10:0] k;
    logic        m;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic  two;
    beat_t b1;
    beat_t b2;
  } plan_t;

  typedef struct {
    logic [15:0] v;
    plan_t       p;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [15:0] valor = 16'd0;
  logic        valor_valid = 1'b0;
  logic        beat_ready = 1'b0;
  logic [15:0] b_valor = 16'd0;
  logic        b_valid = 1'b0;
  logic        b_ready = 1'b0;
  logic [15:0] n_pares_a;
  logic [15:0] n_pares_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  beat_t       exp_q[$];
  logic [15:0] exp_v[$];
  logic [15:0] exp_pares = 16'd0;
  logic [15:0] acc = 16'd0;
  plan_t       pres;

  constant_splitter_if a_if ();
  constant_splitter_if b_if ();

  assign a_if.valor       = valor;
  assign a_if.valor_valid = valor_valid;
  assign a_if.beat_ready  = beat_ready;
  assign b_if.valor       = b_valor;
  assign b_if.valor_valid = b_valid;
  assign b_if.beat_ready  = b_ready;

  constant_splitter #(.ALLOW_ZEXT(1)) dut_a (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (a_if),
    .n_pares (n_pares_a)
  );

  constant_splitter #(.ALLOW_ZEXT(0)) dut_b (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (b_if),
    .n_pares (n_pares_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mkb(input logic [1:0] c, input logic [10:0] k,
                                input logic m, input logic l);
    beat_t b;
    b.c = c; b.k = k; b.m = m; b.l = l;
    return b;
  endfunction

  function automatic plan_t mk1(input logic [1:0] c, input logic [10:0] k);
    plan_t p;
    p.two = 1'b0; p.b1 = mkb(c, k, 1'b0, 1'b1); p.b2 = '0;
    return p;
  endfunction

  function automatic plan_t mk2(input logic [10:0] khi, input logic [10:0] klo);
    plan_t p;
    p.two = 1'b1; p.b1 = mkb(2'b10, khi, 1'b0, 1'b0); p.b2 = mkb(2'b01, klo, 1'b1, 1'b1);
    return p;
  endfunction

  // Reference encoding from the value ranges each extender mode can reach.
  function automatic plan_t encode(input logic [15:0] v, input bit zext);
    int s;
    s = $signed(v);
    if (s >= -1024 && s <= 1023) return mk1(2'b00, v[10:0]);
    if (zext && v < 16'd2048)    return mk1(2'b01, v[10:0]);
    if (v % 256 == 0)            return mk1(2'b10, 11'(v / 256));
    return mk2(11'(v / 256), 11'(v % 256));
  endfunction

  // What the downstream extender rebuilds from one beat.
  function automatic logic [15:0] extend(input beat_t b);
    case (b.c)
      2'b00:   return {{5{b.k[10]}}, b.k};
      2'b01:   return {5'b00000, b.k};
      2'b10:   return {b.k[7:0], 8'h00};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] rand_valor();
    logic [10:0] k;
    logic [15:0] v;
    k = 11'($urandom);
    case ($urandom_range(0, 3))
      0:       v = {{5{k[10]}}, k};
      1:       v = 16'($urandom_range(0, 2047));
      2:       v = {8'($urandom), 8'h00};
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // One cycle on instance A: inputs were set just after the previous rising
  // edge; outputs are checked on the falling edge and the scoreboard follows
  // the handshakes that the coming rising edge will perform.
  task automatic step(output bit accepted);
    bit    exp_vr;
    beat_t got;
    @(negedge clk);
    cyc++;
    exp_vr = (exp_q.size() == 0) || (exp_q.size() == 1 && beat_ready);
    chk("valor_ready", a_if.valor_ready, exp_vr);
    chk("beat_valid", a_if.beat_valid, exp_q.size() != 0);
    got = mkb(a_if.controle, a_if.constante, a_if.merge, a_if.last);
    if (exp_q.size() != 0) chk("beat_fields", 32'(got), 32'(exp_q[0]));
    chk("n_pares", n_pares_a, exp_pares);
    accepted = valor_valid && a_if.valor_ready;
    if (a_if.beat_valid && beat_ready && exp_q.size() != 0) begin
      acc = got.m ? (acc | extend(got)) : extend(got);
      if (got.l && exp_v.size() != 0) chk("round_trip", acc, exp_v.pop_front());
      if (exp_q[0].m && exp_pares != 16'hFFFF) exp_pares++;
      void'(exp_q.pop_front());
    end
    if (accepted) begin
      exp_v.push_back(valor);
      exp_q.push_back(pres.b1);
      if (pres.two) exp_q.push_back(pres.b2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input plan_t p);
    bit acc_ok;
    int t;
    acc_ok = 1'b0;
    t = 0;
    valor = v; valor_valid = 1'b1; pres = p;
    while (!acc_ok && t < 50) begin
      step(acc_ok);
      t++;
    end
    if (!acc_ok) chk("send_timeout", 32'(acc_ok), 32'd1);
    valor_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int t;
    t = 0;
    valor_valid = 1'b0; beat_ready = 1'b1;
    while (exp_q.size() != 0 && t < 20) begin
      step(a);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t tbl[13];

  initial begin
    bit a;
    int start;

    tbl[0]  = '{16'h03FF, mk1(2'b00, 11'h3FF)};
    tbl[1]  = '{16'hFC00, mk1(2'b00, 11'h400)};
    tbl[2]  = '{16'h07FF, mk1(2'b01, 11'h7FF)};
    tbl[3]  = '{16'hAB00, mk1(2'b10, 11'h0AB)};
    tbl[4]  = '{16'h1234, mk2(11'h012, 11'h034)};
    tbl[5]  = '{16'h0000, mk1(2'b00, 11'h000)};
    tbl[6]  = '{16'hFFFF, mk1(2'b00, 11'h7FF)};
    tbl[7]  = '{16'h0800, mk1(2'b10, 11'h008)};
    tbl[8]  = '{16'h8001, mk2(11'h080, 11'h001)};
    tbl[9]  = '{16'h0400, mk1(2'b01, 11'h400)};
    tbl[10] = '{16'h7FFF, mk2(11'h07F, 11'h0FF)};
    tbl[11] = '{16'hFBFF, mk2(11'h0FB, 11'h0FF)};
    tbl[12] = '{16'h0C00, mk1(2'b10, 11'h00C)};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_beat_valid", a_if.beat_valid, 1'b0);
    chk("rst_controle", a_if.controle, 2'b00);
    chk("rst_constante", a_if.constante, 11'h000);
    chk("rst_merge", a_if.merge, 1'b0);
    chk("rst_last", a_if.last, 1'b0);
    chk("rst_n_pares", n_pares_a, 16'd0);
    chk("rst_b_beat_valid", b_if.beat_valid, 1'b0);
    reset_n = 1'b1;
    step(a);

    // Known encodings, one at a time
    beat_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].v, tbl[i].p);
      drain();
      $display("vector %0d valor=0x%04h two=%0b", i, tbl[i].v, tbl[i].p.two);
    end

    // Back-to-back single-beat constants: one accepted per cycle
    beat_ready = 1'b1;
    start = cyc;
    send(16'h0001, encode(16'h0001, 1'b1));
    send(16'h0002, encode(16'h0002, 1'b1));
    send(16'h0003, encode(16'h0003, 1'b1));
    chk("b2b_cycles", 32'(cyc - start), 32'd3);
    drain();
    $display("back-to-back 0001/0002/0003 done");

    // Downstream stall during the first beat of a two-beat constant
    beat_ready = 1'b0;
    send(16'h1234, encode(16'h1234, 1'b1));
    valor = 16'h5555; valor_valid = 1'b1; pres = encode(16'h5555, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(a);
      chk("stall_no_accept", 32'(a), 32'd0);
    end
    beat_ready = 1'b1;
    send(16'h5555, encode(16'h5555, 1'b1));
    drain();
    $display("stall during BEAT1 of 1234 done");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      valor       = rand_valor();
      valor_valid = ($urandom_range(0, 3) != 0);
      beat_ready  = ($urandom_range(0, 9) < 7);
      pres        = encode(valor, 1'b1);
      step(a);
    end
    drain();
    $display("random traffic done n_pares=%0d", exp_pares);

    // ZEXT disabled: 07FF must split, 0400 uses the high-byte form
    b_valor = 16'h07FF; b_valid = 1'b1; b_ready = 1'b1;
    @(negedge clk);
    chk("b_accept_ready", b_if.valor_ready, 1'b1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    chk("b_beat1_valid", b_if.beat_valid, 1'b1);
    chk("b_beat1_controle", b_if.controle, 2'b10);
    chk("b_beat1_constante", b_if.constante, 11'h007);
    chk("b_beat1_merge", b_if.merge, 1'b0);
    chk("b_beat1_last", b_if.last, 1'b0);
    chk("b_beat1_vready", b_if.valor_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_beat2_controle", b_if.controle, 2'b01);
    chk("b_beat2_constante", b_if.constante, 11'h0FF);
    chk("b_beat2_merge", b_if.merge, 1'b1);
    chk("b_beat2_last", b_if.last, 1'b1);
    @(posedge clk); #1;
    b_valor = 16'h0400; b_valid = 1'b1;
    @(negedge clk);
    chk("b_idle_valid", b_if.beat_valid, 1'b0);
    chk("b_n_pares", n_pares_b, 16'd1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    chk("b_0400_controle", b_if.controle, 2'b10);
    chk("b_0400_constante", b_if.constante, 11'h004);
    chk("b_0400_last", b_if.last, 1'b1);
    @(posedge clk); #1;
    $display("ALLOW_ZEXT=0 instance: 07FF split, 0400 high-byte");

    // Reset while the second beat is pending
    beat_ready = 1'b1;
    send(16'h1234, encode(16'h1234, 1'b1));
    step(a);
    chk("pre_reset_beat2", a_if.beat_valid & a_if.merge, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_beat_valid", a_if.beat_valid, 1'b0);
    chk("mid_rst_n_pares", n_pares_a, 16'd0);
    chk("mid_rst_merge", a_if.merge, 1'b0);
    exp_q.delete();
    exp_v.delete();
    exp_pares = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(a);
    send(16'h1234, encode(16'h1234, 1'b1));
    drain();
    $display("reset during BEAT2 done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
